// File: rtl/nibble_adder_scheduler.sv
// ============================================================================
// Module   : nibble_adder_scheduler
// Purpose  : Two-requester round-robin front end sharing one 4-bit add slice
//            to perform WIDTH-bit additions serially, LSB nibble first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_adder_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum,
  output logic             res_id,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] C_LAST_NIB = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;
  logic             r_carry;
  logic             r_id;
  logic             r_msb;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum_lo;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_take;
  logic [CW+1:0]    w_base;
  logic [4:0]       w_nib;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    w_grant0 = req0_valid && (!req1_valid || r_last_grant);
    w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
  end

  always_comb begin
    w_base = {r_cnt, 2'b00};
    w_nib  = {1'b0, r_a[w_base +: 4]} + {1'b0, r_b[w_base +: 4]} + {4'b0000, r_carry};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant0 || w_grant1) begin
          w_take = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == C_LAST_NIB) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_carry      <= 1'b0;
      r_id         <= 1'b0;
      r_msb        <= 1'b0;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_sum_lo     <= '0;
    end else if (w_take) begin
      r_a          <= w_grant0 ? req0_a : req1_a;
      r_b          <= w_grant0 ? req0_b : req1_b;
      r_id         <= w_grant1;
      r_last_grant <= w_grant1;
      r_carry      <= 1'b0;
      r_cnt        <= '0;
    end else if (r_state == RUN) begin
      r_sum_lo[w_base +: 4] <= w_nib[3:0];
      r_carry               <= w_nib[4];
      r_cnt                 <= r_cnt + 1'b1;
      if (r_cnt == C_LAST_NIB) begin
        r_msb <= w_nib[4];
      end
    end
  end

  // Readies are gated by rst so they drop the instant reset is asserted.
  assign req0_ready = !rst && (r_state == IDLE) && w_grant0;
  assign req1_ready = !rst && (r_state == IDLE) && w_grant1;
  assign res_valid  = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign res_sum    = {r_msb, r_sum_lo};
  assign res_id     = r_id;

endmodule

`default_nettype wire

// File: tb/tb_nibble_adder_scheduler.sv
// ============================================================================
// Module   : tb_nibble_adder_scheduler
// Purpose  : Directed and random checks of nibble_adder_scheduler (WIDTH 16/8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_adder_scheduler;

  logic clk;
  logic rst;

  logic        v0_16, v1_16, r0_16, r1_16, rv16, rr16, rid16, busy16;
  logic [15:0] a0_16, b0_16, a1_16, b1_16;
  logic [16:0] rsum16;

  logic        v0_8, v1_8, r0_8, r1_8, rv8, rr8, rid8, busy8;
  logic [7:0]  a0_8, b0_8, a1_8, b1_8;
  logic [8:0]  rsum8;

  int total = 0;
  int bad   = 0;
  logic done8 = 1'b0;

  logic [17:0] got_q [$];

  logic        m_out [2];
  int          m_cd  [2];
  logic [16:0] m_sum [2];
  logic        m_id  [2];
  logic        m_lg  [2];

  nibble_adder_scheduler #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .req0_valid(v0_16), .req0_ready(r0_16), .req0_a(a0_16), .req0_b(b0_16),
    .req1_valid(v1_16), .req1_ready(r1_16), .req1_a(a1_16), .req1_b(b1_16),
    .res_valid(rv16), .res_ready(rr16), .res_sum(rsum16), .res_id(rid16), .busy(busy16)
  );

  nibble_adder_scheduler #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(v0_8), .req0_ready(r0_8), .req0_a(a0_8), .req0_b(b0_8),
    .req1_valid(v1_8), .req1_ready(r1_8), .req1_a(a1_8), .req1_b(b1_8),
    .res_valid(rv8), .res_ready(rr8), .res_sum(rsum8), .res_id(rid8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input int k, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%0b exp=%0b", nm, k, got, exp);
    end
  endtask

  task automatic chkv(input string nm, input int k, input logic [16:0] got, input logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%05h exp=%05h", nm, k, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Transaction-level reference: an accepted operation owns the adder for
  // nib cycles, then its exact sum is offered until the consumer takes it.
  task automatic model_cycle(input int k, input int nib,
                             input logic v0, input logic v1, input logic r0, input logic r1,
                             input logic rv, input logic bsy, input logic rid, input logic rrdy,
                             input logic [16:0] a0, input logic [16:0] b0,
                             input logic [16:0] a1, input logic [16:0] b1,
                             input logic [16:0] rsum);
    logic e0, e1, ev;
    if (rst) begin
      chk1("rst_ready0", k, r0, 1'b0);
      chk1("rst_ready1", k, r1, 1'b0);
      chk1("rst_valid", k, rv, 1'b0);
      chk1("rst_busy", k, bsy, 1'b0);
      chk1("rst_id", k, rid, 1'b0);
      chkv("rst_sum", k, rsum, 17'h0);
      m_out[k] = 1'b0;
      m_cd[k]  = 0;
      m_lg[k]  = 1'b1;
      return;
    end
    e0 = !m_out[k] && v0 && (!v1 || m_lg[k]);
    e1 = !m_out[k] && v1 && (!v0 || !m_lg[k]);
    ev = m_out[k] && (m_cd[k] == 0);
    chk1("ready0", k, r0, e0);
    chk1("ready1", k, r1, e1);
    chk1("busy", k, bsy, m_out[k]);
    chk1("res_valid", k, rv, ev);
    if (ev) begin
      chkv("res_sum", k, rsum, m_sum[k]);
      chk1("res_id", k, rid, m_id[k]);
    end
    if (m_out[k]) begin
      if (m_cd[k] > 0) m_cd[k]--;
      else if (rrdy) m_out[k] = 1'b0;
    end else if (e0 || e1) begin
      m_out[k] = 1'b1;
      m_cd[k]  = nib;
      m_sum[k] = e0 ? (a0 + b0) : (a1 + b1);
      m_id[k]  = e1;
      m_lg[k]  = e1;
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, 4, v0_16, v1_16, r0_16, r1_16, rv16, busy16, rid16, rr16,
                {1'b0, a0_16}, {1'b0, b0_16}, {1'b0, a1_16}, {1'b0, b1_16}, rsum16);
    model_cycle(1, 2, v0_8, v1_8, r0_8, r1_8, rv8, busy8, rid8, rr8,
                {9'b0, a0_8}, {9'b0, b0_8}, {9'b0, a1_8}, {9'b0, b1_8}, {8'b0, rsum8});
    if (!rst && rv16 && rr16) got_q.push_back({rid16, rsum16});
  end

  task automatic wait_results(input int n);
    int i;
    i = 0;
    #1;
    while (got_q.size() < n && i < 200) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (got_q.size() < n) begin
      total++;
      bad++;
      $display("FAIL wait_results got=%0d exp=%0d", got_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pop(input string nm, input logic exp_id, input logic [16:0] exp_sum);
    logic [17:0] e;
    if (got_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s got=none exp=%05h", nm, exp_sum);
    end else begin
      e = got_q.pop_front();
      chk1({nm, "_id"}, 0, e[17], exp_id);
      chkv({nm, "_sum"}, 0, e[16:0], exp_sum);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int which, input logic [15:0] a, input logic [15:0] b);
    int n;
    logic hs;
    if (which == 0) begin v0_16 = 1'b1; a0_16 = a; b0_16 = b; end
    else            begin v1_16 = 1'b1; a1_16 = a; b1_16 = b; end
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk);
      n++;
      hs = (which == 0) ? (r0_16 && v0_16) : (r1_16 && v1_16);
    end
    chk1("send_accepted", 0, hs, 1'b1);
    @(posedge clk);
    #1;
    if (which == 0) v0_16 = 1'b0;
    else            v1_16 = 1'b0;
  endtask

  task automatic measure(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy16) bc++;
    end while (!rv16 && lat < 50);
  endtask

  // Random traffic for the 8-bit instance over the whole run.
  initial begin
    v0_8 = 1'b0; v1_8 = 1'b0; rr8 = 1'b1;
    a0_8 = '0; b0_8 = '0; a1_8 = '0; b1_8 = '0;
    while (!done8) begin
      @(posedge clk);
      #1;
      v0_8 = 1'($urandom);
      v1_8 = 1'($urandom);
      a0_8 = 8'($urandom); b0_8 = 8'($urandom);
      a1_8 = 8'($urandom); b1_8 = 8'($urandom);
      rr8  = ($urandom_range(0, 3) != 0);
    end
    v0_8 = 1'b0;
    v1_8 = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int lat, bc, n, accepts;
    rst = 1'b1;
    v0_16 = 1'b1; a0_16 = 16'h0001; b0_16 = 16'h0002;
    v1_16 = 1'b1; a1_16 = 16'h0010; b1_16 = 16'h0020;
    rr16 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Tie from reset: req0 first, then strict alternation.
    accepts = 0;
    n = 0;
    while (accepts < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (r0_16 && v0_16) accepts++;
      if (r1_16 && v1_16) accepts++;
    end
    @(posedge clk);
    #1;
    v0_16 = 1'b0;
    v1_16 = 1'b0;
    chki("tie_accepts", accepts, 4);
    wait_results(4);
    expect_pop("tie0", 1'b0, 17'h00003);
    expect_pop("tie1", 1'b1, 17'h00030);
    expect_pop("tie2", 1'b0, 17'h00003);
    expect_pop("tie3", 1'b1, 17'h00030);

    send(0, 16'h1234, 16'h0FFF);
    measure(lat, bc);
    chki("single_latency", lat, 5);
    chki("single_busy_cycles", bc, 5);
    wait_results(1);
    expect_pop("single", 1'b0, 17'h02233);

    send(1, 16'hFFFF, 16'h0001);
    send(0, 16'hFFFF, 16'hFFFF);
    wait_results(2);
    expect_pop("carry_chain", 1'b1, 17'h10000);
    expect_pop("overflow", 1'b0, 17'h1FFFE);

    // Back-pressure with a pending req1.
    rr16 = 1'b0;
    send(0, 16'h1234, 16'h4321);
    v1_16 = 1'b1; a1_16 = 16'h0100; b1_16 = 16'h0200;
    n = 0;
    do begin @(negedge clk); n++; end while (!rv16 && n < 50);
    repeat (10) begin
      @(negedge clk);
      chkv("bp_hold_sum", 0, rsum16, 17'h05555);
      chk1("bp_hold_id", 0, rid16, 1'b0);
      chk1("bp_hold_ready1", 0, r1_16, 1'b0);
    end
    @(posedge clk);
    #1 rr16 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!r1_16 && n < 20);
    chki("bp_req1_accept_delay", n, 2);
    @(posedge clk);
    #1 v1_16 = 1'b0;
    wait_results(2);
    expect_pop("bp_first", 1'b0, 17'h05555);
    expect_pop("bp_second", 1'b1, 17'h00300);

    // Abort after nibble 2 is written.
    send(0, 16'hABCD, 16'h1111);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("abort_valid", 0, rv16, 1'b0);
    chk1("abort_busy", 0, busy16, 1'b0);
    chk1("abort_ready0", 0, r0_16, 1'b0);
    chk1("abort_ready1", 0, r1_16, 1'b0);
    chkv("abort_sum", 0, rsum16, 17'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(0, 16'h0005, 16'h0003);
    measure(lat, bc);
    chki("post_reset_latency", lat, 5);
    wait_results(1);
    chki("abort_no_stale_result", got_q.size(), 1);
    expect_pop("post_reset", 1'b0, 17'h00008);

    // Random regression on the 16-bit instance.
    repeat (400) begin
      @(posedge clk);
      #1;
      v0_16 = 1'($urandom);
      v1_16 = 1'($urandom);
      a0_16 = 16'($urandom); b0_16 = 16'($urandom);
      a1_16 = 16'($urandom); b1_16 = 16'($urandom);
      rr16  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    v0_16 = 1'b0;
    v1_16 = 1'b0;
    rr16  = 1'b1;
    done8 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
